// File: rtl/lfo_delay_mod_pkg.sv
// Shared types and constants for the LFO-modulated delay-line address generator.
package lfo_delay_mod_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned MUL_STEPS      = 8;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StSum,
        StOut
    } slot_state_e;

endpackage

// File: rtl/lfo_serial_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, done pulses after the last step.
module lfo_serial_mul
    import lfo_delay_mod_pkg::*;
#(
    parameter int unsigned LFO_W = MUL_STEPS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LFO_W-1:0]   a,
    input  logic [LFO_W-1:0]   b,
    output logic [2*LFO_W-1:0] p,
    output logic               done
);

    localparam int unsigned P_W  = 2 * LFO_W;
    localparam int unsigned SW   = $clog2(LFO_W);

    logic [LFO_W-1:0] a_q, b_q;
    logic [P_W-1:0]   p_q;
    logic [SW-1:0]    step_q;
    logic             run_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= b;
                p_q    <= '0;
                step_q <= '0;
                run_q  <= 1'b1;
            end else if (run_q) begin
                if (b_q[step_q]) begin
                    p_q <= p_q + (P_W'(a_q) << step_q);
                end
                step_q <= step_q + SW'(1);
                if (step_q == SW'(LFO_W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign p    = p_q;
    assign done = done_q;

endmodule

// File: rtl/lfo_delay_mod.sv
// Per-sample-slot delay-line address generator: read address = write pointer - base delay
// - (LFO * DEPTH) / 256, with CPU-writable DEPTH and DELAY registers.
module lfo_delay_mod
    import lfo_delay_mod_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned LFO_W  = MUL_STEPS
) (
    input  logic              CK,
    input  logic              nRES,
    input  logic [7:0]        PIN_DB_IN,
    input  logic              nWR_DEPTH,
    input  logic              nWR_DLY_L,
    input  logic              nWR_DLY_H,
    input  logic [LFO_W-1:0]  LFO,
    input  logic              SYNC,
    output logic [ADDR_W-1:0] RADDR,
    output logic [ADDR_W-1:0] WADDR,
    output logic              ADDR_VALID,
    output logic              BUSY,
    output logic              OVERRUN
);

    logic [LFO_W-1:0]   depth_l, depth_q;
    logic [7:0]         dly_lo_l;
    logic [ADDR_W-9:0]  dly_hi_l;
    logic [ADDR_W-1:0]  delay_q, d_q, wptr_q;
    logic [2*LFO_W-1:0] mul_p;
    logic [LFO_W-1:0]   mod_term;
    logic               mul_done, accept;
    slot_state_e        state_q, state_d;

    // CPU bus latches are transparent while the strobe is low; re-timed into CK below.
    always_latch begin
        if (!nRES) begin
            depth_l = '0;
        end else if (!nWR_DEPTH) begin
            depth_l = LFO_W'(PIN_DB_IN);
        end
    end

    always_latch begin
        if (!nRES) begin
            dly_lo_l = '0;
        end else if (!nWR_DLY_L) begin
            dly_lo_l = PIN_DB_IN;
        end
    end

    always_latch begin
        if (!nRES) begin
            dly_hi_l = '0;
        end else if (!nWR_DLY_H) begin
            dly_hi_l = PIN_DB_IN[ADDR_W-9:0];
        end
    end

    assign accept   = SYNC && (state_q == StIdle);
    assign mod_term = mul_p[2*LFO_W-1:LFO_W];

    lfo_serial_mul #(
        .LFO_W (LFO_W)
    ) u_mul (
        .clk   (CK),
        .rst_n (nRES),
        .start (accept),
        .a     (LFO),
        .b     (depth_q),
        .p     (mul_p),
        .done  (mul_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (SYNC) state_d = StMul;
            StMul:   if (mul_done) state_d = StSum;
            StSum:   state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK or negedge nRES) begin
        if (!nRES) begin
            state_q <= StIdle;
            depth_q <= '0;
            delay_q <= '0;
            d_q     <= '0;
            wptr_q  <= '0;
            RADDR   <= '0;
            WADDR   <= '0;
            OVERRUN <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_l;
            delay_q <= {dly_hi_l, dly_lo_l};
            if (accept) begin
                d_q <= delay_q;
            end
            if (state_q == StSum) begin
                RADDR  <= wptr_q - d_q - ADDR_W'(mod_term);
                WADDR  <= wptr_q;
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            // A sample slot that starts before the previous one finished is dropped.
            if (SYNC && (state_q != StIdle)) begin
                OVERRUN <= 1'b1;
            end
        end
    end

    assign ADDR_VALID = (state_q == StOut);
    assign BUSY       = (state_q != StIdle);

endmodule
